// File: rtl/rhythm_pkg.sv
// rhythm_pkg: shared encodings and constants for the rhythm lane blocks
package rhythm_pkg;
    typedef enum logic [1:0] {IDLE, FALL, GAP} fsm_t;
    localparam logic [2:0] POS_BLANK   = 3'd0;
    localparam logic [2:0] POS_FIRST   = 3'd1;
    localparam logic [2:0] POS_GOOD    = 3'd6;
    localparam logic [2:0] POS_PERFECT = 3'd7;
    localparam int COMBO_W = 8;
endpackage

// File: rtl/rhythm_tick_gen.sv
// rhythm_tick_gen: divide-by-TICK_DIV counter with enable, clear and terminal-count strobe
module rhythm_tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);
    localparam int CW = $clog2(TICK_DIV);
    logic [CW-1:0] r_cnt;
    assign o_tc = i_en && (r_cnt == CW'(TICK_DIV - 1));
    // count while enabled, wrap at terminal count, clear has priority
    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_tc ? '0 : r_cnt + CW'(1);
    end
endmodule

// File: rtl/rhythm_lane_ctrl.sv
// rhythm_lane_ctrl: one falling-note lane with launch queue, hit judgement and combo counter
module rhythm_lane_ctrl
    import rhythm_pkg::*;
#(
    parameter int TICK_DIV   = 5000000,
    parameter int QDEPTH_MAX = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_hit,
    input  logic               i_pause,
    output logic [2:0]         o_state,
    output logic               o_busy,
    output logic               o_perfect,
    output logic               o_good,
    output logic               o_miss,
    output logic               o_overflow,
    output logic [COMBO_W-1:0] o_combo
);
    localparam int PW = $clog2(QDEPTH_MAX + 1);
    fsm_t               r_fsm, w_fsm_nxt;
    logic [2:0]         r_state, w_state_nxt;
    logic [PW-1:0]      r_pending, w_pend_nxt;
    logic [COMBO_W-1:0] r_combo, w_combo_nxt;
    logic               r_busy, r_perfect, r_good, r_miss, r_overflow;
    logic               w_perfect, w_good, w_miss, w_launch, w_start_acc;
    logic               w_en, w_clr, w_tc, w_judge;
    assign w_judge     = (r_fsm == FALL) && i_hit && !i_pause;
    assign w_launch    = (r_fsm == IDLE) && (r_pending != '0) && !i_pause;
    assign w_start_acc = i_start && ((r_pending < PW'(QDEPTH_MAX)) || w_launch);
    assign w_pend_nxt  = r_pending + PW'(w_start_acc) - PW'(w_launch);
    assign w_en        = (r_fsm != IDLE) && !i_pause;
    assign w_clr       = (r_fsm == IDLE) || w_judge;
    rhythm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_en),
        .i_clr(w_clr),
        .o_tc (w_tc)
    );
    // next-state, position and judgement decode; a hit outranks a same-cycle tick
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_perfect   = 1'b0;
        w_good      = 1'b0;
        w_miss      = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (w_launch) begin
                    w_fsm_nxt   = FALL;
                    w_state_nxt = POS_FIRST;
                end
            end
            FALL: begin
                if (w_judge) begin
                    w_fsm_nxt   = GAP;
                    w_state_nxt = POS_BLANK;
                    w_perfect   = r_state == POS_PERFECT;
                    w_good      = r_state == POS_GOOD;
                    w_miss      = r_state < POS_GOOD;
                end else if (w_tc) begin
                    w_fsm_nxt   = (r_state == POS_PERFECT) ? GAP : FALL;
                    w_state_nxt = (r_state == POS_PERFECT) ? POS_BLANK : r_state + 3'd1;
                    w_miss      = r_state == POS_PERFECT;
                end
            end
            GAP: w_fsm_nxt = w_tc ? IDLE : GAP;
            default: begin
                w_fsm_nxt   = IDLE;
                w_state_nxt = POS_BLANK;
            end
        endcase
        w_combo_nxt = w_miss ? '0 : ((w_perfect || w_good) && !(&r_combo)) ? r_combo + COMBO_W'(1) : r_combo;
    end
    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm      <= IDLE;
            r_state    <= POS_BLANK;
            r_pending  <= '0;
            r_combo    <= '0;
            r_busy     <= 1'b0;
            r_perfect  <= 1'b0;
            r_good     <= 1'b0;
            r_miss     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_state    <= w_state_nxt;
            r_pending  <= w_pend_nxt;
            r_combo    <= w_combo_nxt;
            r_busy     <= (w_fsm_nxt != IDLE) || (w_pend_nxt != '0);
            r_perfect  <= w_perfect;
            r_good     <= w_good;
            r_miss     <= w_miss;
            r_overflow <= i_start && !w_start_acc;
        end
    end
    assign o_state    = r_state;
    assign o_busy     = r_busy;
    assign o_perfect  = r_perfect;
    assign o_good     = r_good;
    assign o_miss     = r_miss;
    assign o_overflow = r_overflow;
    assign o_combo    = r_combo;
endmodule

// File: tb/tb_rhythm_lane_ctrl.sv
// tb_rhythm_lane_ctrl: directed self-checking bench for rhythm_lane_ctrl with TICK_DIV=4
module tb_rhythm_lane_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_hit = 1'b0;
    logic       i_pause = 1'b0;
    logic [2:0] o_state;
    logic       o_busy, o_perfect, o_good, o_miss, o_overflow;
    logic [7:0] o_combo;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    rhythm_lane_ctrl #(.TICK_DIV(4), .QDEPTH_MAX(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_hit     (i_hit),
        .i_pause   (i_pause),
        .o_state   (o_state),
        .o_busy    (o_busy),
        .o_perfect (o_perfect),
        .o_good    (o_good),
        .o_miss    (o_miss),
        .o_overflow(o_overflow),
        .o_combo   (o_combo)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask
    task automatic pulse_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask
    task automatic pulse_hit();
        i_hit = 1'b1;
        step();
        i_hit = 1'b0;
    endtask
    task automatic wait_state(input logic [2:0] v);
        int n = 0;
        while (o_state != v && n < 200) begin
            step();
            n++;
        end
        check("wait_state", o_state, v);
    endtask
    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 200) begin
            step();
            n++;
        end
        check("wait_idle", o_busy, 0);
    endtask
    initial begin
        int  n;
        bit  any_pulse;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        check("rst_state", o_state, 0);
        check("rst_busy", o_busy, 0);
        check("rst_combo", o_combo, 0);
        check("rst_pulses", {o_perfect, o_good, o_miss, o_overflow}, 0);
        run_to(10);
        pulse_start();
        check("pend_busy", o_busy, 1);
        check("pre_launch", o_state, 0);
        step();
        check("launch_c12", o_state, 1);
        run_to(16);
        check("step_c16", o_state, 2);
        run_to(35);
        check("c35_state", o_state, 6);
        step();
        check("c36_state", o_state, 7);
        run_to(39);
        check("c39_nomiss", o_miss, 0);
        step();
        check("c40_miss", o_miss, 1);
        check("c40_state", o_state, 0);
        check("c40_combo", o_combo, 0);
        step();
        check("miss_1cyc", o_miss, 0);
        run_to(43);
        check("c43_busy", o_busy, 1);
        step();
        check("c44_busy", o_busy, 0);
        pulse_start();
        wait_state(7);
        pulse_hit();
        check("perf_pulse", o_perfect, 1);
        check("perf_state", o_state, 0);
        check("perf_combo", o_combo, 1);
        step();
        check("perf_1cyc", o_perfect, 0);
        wait_idle();
        pulse_start();
        wait_state(6);
        pulse_hit();
        check("good_pulse", o_good, 1);
        check("good_combo", o_combo, 2);
        wait_idle();
        pulse_start();
        wait_state(3);
        pulse_hit();
        check("early_miss", o_miss, 1);
        check("early_combo", o_combo, 0);
        wait_idle();
        pulse_start();
        wait_state(7);
        step();
        step();
        step();
        pulse_hit();
        check("tc_hit_perf", o_perfect, 1);
        check("tc_hit_nomiss", o_miss, 0);
        check("tc_hit_combo", o_combo, 1);
        wait_idle();
        pulse_start();
        wait_state(2);
        i_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ovf_seq", o_overflow, (i == 3) ? 1 : 0);
        end
        i_start = 1'b0;
        step();
        check("ovf_1cyc", o_overflow, 0);
        pulse_hit();
        check("q_hit_miss", o_miss, 1);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (o_state == 0 && n < 50) begin
                n++;
                step();
            end
            check("gap_len", n, 5);
            check("q_launch", o_state, 1);
            pulse_hit();
        end
        wait_idle();
        for (int i = 0; i < 20; i++) step();
        check("q_empty", o_state, 0);
        pulse_start();
        wait_state(4);
        step();
        i_pause = 1'b1;
        any_pulse = 1'b0;
        for (int i = 0; i < 100; i++) begin
            i_hit = (i == 50);
            step();
            any_pulse |= o_perfect | o_good | o_miss;
        end
        i_hit = 1'b0;
        check("pause_state", o_state, 4);
        check("pause_nopulse", any_pulse, 0);
        i_pause = 1'b0;
        step();
        check("resume_1", o_state, 4);
        step();
        check("resume_2", o_state, 4);
        step();
        check("resume_step", o_state, 5);
        pulse_hit();
        check("resume_miss", o_miss, 1);
        wait_idle();
        for (int k = 0; k < 255; k++) begin
            pulse_start();
            n = 0;
            while (o_state != 6 && n < 200) begin
                step();
                n++;
            end
            pulse_hit();
            n = 0;
            while (o_busy && n < 200) begin
                step();
                n++;
            end
        end
        check("combo_255", o_combo, 255);
        pulse_start();
        wait_state(7);
        pulse_hit();
        check("sat_perf", o_perfect, 1);
        check("sat_combo", o_combo, 255);
        wait_idle();
        i_start = 1'b1;
        step();
        step();
        step();
        i_start = 1'b0;
        wait_state(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_state", o_state, 0);
        check("mrst_combo", o_combo, 0);
        check("mrst_busy", o_busy, 0);
        check("mrst_pulses", {o_perfect, o_good, o_miss}, 0);
        any_pulse = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            any_pulse |= o_busy | (o_state != 0);
        end
        check("mrst_pending0", any_pulse, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
